// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl: push-button front end (synchronise, debounce, IDLE/RUN/PAUSE FSM, prescaler) that drives a down counter's ena/clr.
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   btn_start  raw start/resume button
//   btn_stop   raw pause button
//   btn_clear  raw clear button
//   btn_step   raw single-step button
//   cnt_ena    one-cycle count-enable pulse
//   cnt_clr    one-cycle clear pulse
//   run_led    high while in RUN
//   state      IDLE=00, RUN=01, PAUSE=10
module count_enable_ctrl #(
    parameter int DIV_VALUE = 12500000,
    parameter int DIV_BITS  = 24,
    parameter int DB_CYCLES = 250000,
    parameter int DB_BITS   = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       btn_step,
    output logic       cnt_ena,
    output logic       cnt_clr,
    output logic       run_led,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, BAD = 2'b11} state_t;
    state_t state_q, state_n;
    logic [3:0] raw, s0, s1, db, db_q, press;
    logic [DB_BITS-1:0] dbc [4];
    logic [DIV_BITS-1:0] presc, presc_n;
    logic p_clr, p_stop, p_start, p_step, wrap, ena_n, clr_n;
    assign raw = {btn_step, btn_start, btn_stop, btn_clear};
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0   <= '0;
            s1   <= '0;
            db   <= '0;
            db_q <= '0;
            for (int k = 0; k < 4; k++) dbc[k] <= '0;
        end else begin
            s0   <= raw;
            s1   <= s0;
            db_q <= db;
            for (int k = 0; k < 4; k++) begin
                if (s1[k] == db[k]) dbc[k] <= '0;
                else if (dbc[k] == DB_BITS'(DB_CYCLES - 1)) begin
                    db[k]  <= s1[k];
                    dbc[k] <= '0;
                end else dbc[k] <= dbc[k] + 1'b1;
            end
        end
    end
    // Rising edge of the debounced level only; only the highest-priority press survives.
    assign press   = db & ~db_q;
    assign p_clr   = press[0];
    assign p_stop  = press[1] & ~press[0];
    assign p_start = press[2] & ~|press[1:0];
    assign p_step  = press[3] & ~|press[2:0];
    assign wrap    = presc == DIV_BITS'(DIV_VALUE - 1);
    always_comb begin
        state_n = IDLE;
        presc_n = '0;
        ena_n   = 1'b0;
        clr_n   = 1'b0;
        case (state_q)
            IDLE: begin
                clr_n   = p_clr;
                ena_n   = p_step;
                state_n = p_start ? RUN : IDLE;
            end
            RUN: begin
                clr_n   = p_clr;
                state_n = p_clr ? IDLE : (p_stop ? PAUSE : RUN);
                presc_n = p_clr ? '0 : (p_stop ? presc : (wrap ? '0 : presc + 1'b1));
                // A clear or stop landing on the wrap cycle swallows that tick.
                ena_n   = !p_clr && !p_stop && wrap;
            end
            PAUSE: begin
                clr_n   = p_clr;
                ena_n   = p_step;
                state_n = p_clr ? IDLE : (p_start ? RUN : PAUSE);
                presc_n = p_clr ? '0 : presc;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            presc   <= '0;
            cnt_ena <= 1'b0;
            cnt_clr <= 1'b0;
            run_led <= 1'b0;
        end else begin
            state_q <= state_n;
            presc   <= presc_n;
            cnt_ena <= ena_n;
            cnt_clr <= clr_n;
            run_led <= state_n == RUN;
        end
    end
    assign state = state_q;
endmodule
